fm_mem_responder: RTL and testbench

// - Far-memory (FM) responder: the FM-side end of the d_cache FM interface.
// - Accepts cache-line FILL (read) and DIRTY_EVICT (write) requests into an in-order request FIFO.
// - Services them against a line-wide memory array and returns FILL data after a programmable latency.
// - Sits below d_mem_ss in the big_core_cachel1 top and in the cache-level testbench.

---
 rtl/fm_mem_responder.sv | 158 +++++++++++++++
 tb/tb_fm_mem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_mem_responder.sv
// Far-memory responder: in-order FIFO of FILL/DIRTY_EVICT line requests served from a line array.
// Optional latency jitter (16-bit LFSR) is built when FM_LAT_JITTER_EN is defined.
module fm_mem_responder #(
   parameter int unsigned LINE_W      = 128,
   parameter int unsigned LINE_ADR_W  = 24,
   parameter int unsigned MEM_LINES_W = 10,
   parameter int unsigned TQ_ID_W     = 3,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned RD_LATENCY  = 8
) (
   input  logic                  Clock,
   input  logic                  Rst,
   input  logic                  ReqValid,
   input  logic [1:0]            ReqOpcode,
   input  logic [TQ_ID_W-1:0]    ReqTqId,
   input  logic [LINE_ADR_W-1:0] ReqLineAddr,
   input  logic [LINE_W-1:0]     ReqData,
   output logic                  RspValid,
   output logic [TQ_ID_W-1:0]    RspTqId,
   output logic [LINE_ADR_W-1:0] RspLineAddr,
   output logic [LINE_W-1:0]     RspData,
   output logic                  FifoOverflow,
   output logic [7:0]            BadOpCnt
);

   localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned LAT_W     = 9;
   localparam int unsigned ENT_W     = 1 + TQ_ID_W + LINE_ADR_W + LINE_W;
   localparam int unsigned MEM_DEPTH = 1 << MEM_LINES_W;

   typedef enum logic [1:0] {StIdle, StLat, StRsp} state_t;

   logic [ENT_W-1:0]      r_fifo [FIFO_DEPTH];
   logic [LINE_W-1:0]     r_mem  [MEM_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   state_t                r_state;
   logic [LAT_W-1:0]      r_lat_cnt;
   logic [TQ_ID_W-1:0]    r_cap_id, r_rsp_id;
   logic [LINE_ADR_W-1:0] r_cap_addr, r_rsp_addr;
   logic [LINE_W-1:0]     r_cap_data, r_rsp_data;
   logic                  r_rsp_valid;
   logic                  r_overflow;
   logic [7:0]            r_bad_cnt;

   logic                   w_legal, w_in_fill, w_empty, w_full, w_push, w_pop, w_fill_pop;
   logic                   w_head_fill;
   logic [TQ_ID_W-1:0]     w_head_id;
   logic [LINE_ADR_W-1:0]  w_head_addr;
   logic [LINE_W-1:0]      w_head_data;
   logic [MEM_LINES_W-1:0] w_idx;
   logic [LAT_W-1:0]       w_lat_load;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_in_fill = (ReqOpcode == 2'b01);
   assign w_legal   = w_in_fill || (ReqOpcode == 2'b10);
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop     = !Rst && (r_state == StIdle) && !w_empty;
   // A push to a full FIFO is still accepted when the head leaves in the same cycle.
   assign w_push    = !Rst && ReqValid && w_legal && (!w_full || w_pop);

   assign {w_head_fill, w_head_id, w_head_addr, w_head_data} = r_fifo[r_rd_ptr];
   assign w_idx      = w_head_addr[MEM_LINES_W-1:0];
   assign w_fill_pop = w_pop && w_head_fill;

`ifdef FM_LAT_JITTER_EN
   logic [15:0] r_lfsr;
   logic        w_lfsr_fb;

   assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_lat_load = LAT_W'(RD_LATENCY - 1) + LAT_W'(r_lfsr[1:0]);

   always_ff @(posedge Clock) begin
      if (Rst) begin
         r_lfsr <= 16'hACE1;
      end else if (w_fill_pop) begin
         r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      end
   end
`else
   assign w_lat_load = LAT_W'(RD_LATENCY - 1);
`endif

   // Storage arrays carry no reset.
   always_ff @(posedge Clock) begin
      if (w_push) begin
         r_fifo[r_wr_ptr] <= {w_in_fill, ReqTqId, ReqLineAddr, ReqData};
      end
      if (w_pop && !w_head_fill) begin
         r_mem[w_idx] <= w_head_data;
      end
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_state     <= StIdle;
         r_lat_cnt   <= '0;
         r_cap_id    <= '0;
         r_cap_addr  <= '0;
         r_cap_data  <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_addr  <= '0;
         r_rsp_data  <= '0;
         r_overflow  <= 1'b0;
         r_bad_cnt   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         if (w_push && !w_pop) r_count <= r_count + CNT_W'(1);
         if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
         if (ReqValid && w_legal && !w_push) r_overflow <= 1'b1;
         if (ReqValid && !w_legal && (r_bad_cnt != 8'hFF)) r_bad_cnt <= r_bad_cnt + 8'd1;

         r_rsp_valid <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_fill_pop) begin
                  r_cap_id   <= w_head_id;
                  r_cap_addr <= w_head_addr;
                  r_cap_data <= r_mem[w_idx];
                  r_lat_cnt  <= w_lat_load;
                  r_state    <= StLat;
               end
            end
            StLat: begin
               if (r_lat_cnt <= LAT_W'(1)) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_id    <= r_cap_id;
                  r_rsp_addr  <= r_cap_addr;
                  r_rsp_data  <= r_cap_data;
                  r_state     <= StRsp;
               end else begin
                  r_lat_cnt <= r_lat_cnt - LAT_W'(1);
               end
            end
            StRsp:   r_state <= StIdle;
            default: r_state <= StIdle;
         endcase
      end
   end

   assign RspValid     = r_rsp_valid;
   assign RspTqId      = r_rsp_id;
   assign RspLineAddr  = r_rsp_addr;
   assign RspData      = r_rsp_data;
   assign FifoOverflow = r_overflow;
   assign BadOpCnt     = r_bad_cnt;

endmodule

// File: tb/tb_fm_mem_responder.sv
// Self-checking bench for fm_mem_responder (default build, jitter off): vector table,
// directed multi-cycle sequences and a randomized run against a request-level reference model.
module tb_fm_mem_responder;

   localparam int RD_LAT     = 8;
   localparam int FIFO_DEPTH = 8;
   localparam logic [1:0] OP_FILL  = 2'b01;
   localparam logic [1:0] OP_EVICT = 2'b10;
   localparam logic [127:0] D_A = 128'hDEAD_BEEF_0000_1111_2222_3333_DEAD_BEEF;
   localparam logic [127:0] D_B = 128'h0BAD_F00D_4444_5555_6666_7777_0BAD_F00D;
   localparam logic [127:0] D_C = 128'hCAFE_0001_8888_9999_AAAA_BBBB_CAFE_0001;
   localparam logic [127:0] D_D = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
   localparam logic [127:0] D_E = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;

   logic         Clock = 1'b0;
   logic         Rst = 1'b1;
   logic         ReqValid = 1'b0;
   logic [1:0]   ReqOpcode = 2'b00;
   logic [2:0]   ReqTqId = '0;
   logic [23:0]  ReqLineAddr = '0;
   logic [127:0] ReqData = '0;
   logic         RspValid;
   logic [2:0]   RspTqId;
   logic [23:0]  RspLineAddr;
   logic [127:0] RspData;
   logic         FifoOverflow;
   logic [7:0]   BadOpCnt;

   int n_checks = 0;
   int n_err = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   fm_mem_responder #(
      .LINE_W(128), .LINE_ADR_W(24), .MEM_LINES_W(10), .TQ_ID_W(3),
      .FIFO_DEPTH(FIFO_DEPTH), .RD_LATENCY(RD_LAT)
   ) u_dut (
      .Clock(Clock), .Rst(Rst), .ReqValid(ReqValid), .ReqOpcode(ReqOpcode),
      .ReqTqId(ReqTqId), .ReqLineAddr(ReqLineAddr), .ReqData(ReqData),
      .RspValid(RspValid), .RspTqId(RspTqId), .RspLineAddr(RspLineAddr), .RspData(RspData),
      .FifoOverflow(FifoOverflow), .BadOpCnt(BadOpCnt)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   typedef struct {
      int           t;
      logic [2:0]   id;
      logic [23:0]  addr;
      logic [127:0] data;
      bit           known;
   } rsp_t;

   typedef struct {
      int           s;
      int           idx;
      logic [127:0] d;
   } wr_t;

   typedef struct {
      logic [1:0]   op;
      logic [2:0]   id;
      logic [23:0]  addr;
      logic [127:0] data;
      int           exp_rsp;
      logic [127:0] exp_data;
      logic [7:0]   exp_bad;
   } vec_t;

   rsp_t log_q[$];
   rsp_t exp_q[$];
   wr_t  m_wr[$];
   int   m_occ[$];
   logic [127:0] m_mem [int];
   int   m_tfree = 0;
   bit   m_ovf = 1'b0;
   int   m_bad = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: each request is a job served in order by one server; an evict occupies
   // it for one cycle, a fill for RD_LAT+1 cycles with the response in its last cycle.
   function automatic void commit(input int upto);
      while (m_wr.size() > 0 && m_wr[0].s < upto) begin
         m_mem[m_wr[0].idx] = m_wr[0].d;
         void'(m_wr.pop_front());
      end
   endfunction

   function automatic void lookup(input int idx, output logic [127:0] d, output bit known);
      for (int i = m_wr.size() - 1; i >= 0; i--) begin
         if (m_wr[i].idx == idx) begin
            d = m_wr[i].d;
            known = 1'b1;
            return;
         end
      end
      known = m_mem.exists(idx);
      d = known ? m_mem[idx] : '0;
   endfunction

   function automatic void model_push(input int p, input logic [1:0] op, input logic [2:0] id,
                                      input logic [23:0] addr, input logic [127:0] data);
      int   s;
      int   idx;
      rsp_t e;
      if (op != OP_FILL && op != OP_EVICT) begin
         if (m_bad < 255) m_bad++;
         return;
      end
      while (m_occ.size() > 0 && m_occ[0] <= p) void'(m_occ.pop_front());
      if (m_occ.size() >= FIFO_DEPTH) begin
         m_ovf = 1'b1;
         return;
      end
      commit(p);
      s = (p + 1 > m_tfree) ? p + 1 : m_tfree;
      m_occ.push_back(s);
      idx = int'(addr[9:0]);
      if (op == OP_EVICT) begin
         m_wr.push_back('{s: s, idx: idx, d: data});
         m_tfree = s + 1;
      end else begin
         e.t = s + RD_LAT;
         e.id = id;
         e.addr = addr;
         lookup(idx, e.data, e.known);
         exp_q.push_back(e);
         m_tfree = s + RD_LAT + 1;
      end
   endfunction

   function automatic void model_reset(input int r);
      commit(r);
      m_wr.delete();
      m_occ.delete();
      exp_q.delete();
      m_tfree = 0;
      m_ovf = 1'b0;
      m_bad = 0;
   endfunction

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input logic [1:0] op, input logic [2:0] id, input logic [23:0] addr,
                       input logic [127:0] data);
      ReqValid = 1'b1;
      ReqOpcode = op;
      ReqTqId = id;
      ReqLineAddr = addr;
      ReqData = data;
      model_push(cyc, op, id, addr, data);
      step();
      ReqValid = 1'b0;
      ReqOpcode = 2'b00;
   endtask

   task automatic do_reset(input int n);
      model_reset(cyc);
      Rst = 1'b1;
      repeat (n) step();
      Rst = 1'b0;
   endtask

   always @(negedge Clock) begin
      if (RspValid) log_q.push_back('{t: cyc, id: RspTqId, addr: RspLineAddr, data: RspData,
                                      known: 1'b1});
   end

   always @(negedge Clock) begin
      if (mon_en) begin
         bit exp_now;
         exp_now = (exp_q.size() > 0) && (exp_q[0].t == cyc);
         check($sformatf("rnd_valid@%0d", cyc), 128'(RspValid), 128'(exp_now));
         if (exp_now) begin
            if (RspValid) begin
               check("rnd_id", 128'(RspTqId), 128'(exp_q[0].id));
               check("rnd_addr", 128'(RspLineAddr), 128'(exp_q[0].addr));
               if (exp_q[0].known) check("rnd_data", RspData, exp_q[0].data);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   vec_t vecs[11];

   initial begin
      int t0;
      vecs[0]  = '{OP_EVICT, 3'd0, 24'h000010, D_A, 0, 128'd0, 8'd0};
      vecs[1]  = '{OP_FILL,  3'd3, 24'h000010, D_C, 1, D_A,    8'd0};
      vecs[2]  = '{OP_EVICT, 3'd0, 24'h000400, D_B, 0, 128'd0, 8'd0};
      vecs[3]  = '{OP_FILL,  3'd5, 24'h000000, D_C, 1, D_B,    8'd0};
      vecs[4]  = '{2'b11,    3'd1, 24'h000020, D_D, 0, 128'd0, 8'd1};
      vecs[5]  = '{OP_FILL,  3'd6, 24'h010410, D_D, 1, D_A,    8'd1};
      vecs[6]  = '{2'b00,    3'd2, 24'h000010, D_D, 0, 128'd0, 8'd2};
      vecs[7]  = '{OP_EVICT, 3'd0, 24'hFFFFFF, D_C, 0, 128'd0, 8'd2};
      vecs[8]  = '{OP_FILL,  3'd7, 24'h0003FF, D_A, 1, D_C,    8'd2};
      vecs[9]  = '{OP_EVICT, 3'd0, 24'h000010, D_D, 0, 128'd0, 8'd2};
      vecs[10] = '{OP_FILL,  3'd0, 24'hABC010, D_A, 1, D_D,    8'd2};

      do_reset(3);
      check("rst_valid", 128'(RspValid), 128'd0);
      check("rst_id", 128'(RspTqId), 128'd0);
      check("rst_addr", 128'(RspLineAddr), 128'd0);
      check("rst_data", RspData, 128'd0);
      check("rst_ovf", 128'(FifoOverflow), 128'd0);
      check("rst_badcnt", 128'(BadOpCnt), 128'd0);

      for (int i = 0; i < 11; i++) begin
         t0 = cyc;
         log_q.delete();
         send(vecs[i].op, vecs[i].id, vecs[i].addr, vecs[i].data);
         idle(14);
         check($sformatf("vec%0d_count", i), 128'(log_q.size()), 128'(vecs[i].exp_rsp));
         if (log_q.size() > 0) begin
            check($sformatf("vec%0d_lat", i), 128'(log_q[0].t - t0), 128'(RD_LAT + 1));
            check($sformatf("vec%0d_id", i), 128'(log_q[0].id), 128'(vecs[i].id));
            check($sformatf("vec%0d_addr", i), 128'(log_q[0].addr), 128'(vecs[i].addr));
            check($sformatf("vec%0d_data", i), log_q[0].data, vecs[i].exp_data);
         end
         check($sformatf("vec%0d_badcnt", i), 128'(BadOpCnt), 128'(vecs[i].exp_bad));
      end

      // Evict immediately followed by a fill of the same line.
      t0 = cyc;
      log_q.delete();
      send(OP_EVICT, 3'd0, 24'h000010, D_E);
      send(OP_FILL, 3'd3, 24'h000010, '0);
      idle(16);
      check("wr_rd_count", 128'(log_q.size()), 128'd1);
      if (log_q.size() > 0) begin
         check("wr_rd_time", 128'(log_q[0].t - t0), 128'd10);
         check("wr_rd_id", 128'(log_q[0].id), 128'd3);
         check("wr_rd_addr", 128'(log_q[0].addr), 128'h10);
         check("wr_rd_data", log_q[0].data, D_E);
      end

      // Back-to-back fills.
      t0 = cyc;
      log_q.delete();
      send(OP_FILL, 3'd0, 24'h000010, '0);
      send(OP_FILL, 3'd1, 24'h0003FF, '0);
      send(OP_FILL, 3'd2, 24'h000000, '0);
      send(OP_FILL, 3'd3, 24'h000010, '0);
      idle(45);
      check("b2b_count", 128'(log_q.size()), 128'd4);
      for (int i = 0; i < log_q.size(); i++) begin
         check($sformatf("b2b%0d_id", i), 128'(log_q[i].id), 128'(i));
         check($sformatf("b2b%0d_time", i), 128'(log_q[i].t - t0), 128'(9 + 9 * i));
      end
      if (log_q.size() == 4) begin
         check("b2b1_data", log_q[1].data, D_C);
         check("b2b2_data", log_q[2].data, D_B);
         check("b2b3_data", log_q[3].data, D_E);
      end

      // Overflow: ten consecutive fills into an eight-entry FIFO.
      t0 = cyc;
      log_q.delete();
      for (int i = 0; i < 10; i++) begin
         send(OP_FILL, 3'(i), 24'(i), '0);
         if (i == 8) check("ovf_before_10th", 128'(FifoOverflow), 128'd0);
         if (i == 9) check("ovf_after_10th", 128'(FifoOverflow), 128'd1);
      end
      idle(101);
      check("ovf_count", 128'(log_q.size()), 128'd9);
      for (int i = 0; i < log_q.size(); i++) begin
         check($sformatf("ovf%0d_addr", i), 128'(log_q[i].addr), 128'(i));
         check($sformatf("ovf%0d_time", i), 128'(log_q[i].t - t0), 128'(9 + 9 * i));
      end
      check("ovf_sticky", 128'(FifoOverflow), 128'd1);
      do_reset(1);
      check("ovf_cleared", 128'(FifoOverflow), 128'd0);

      // Reset three cycles after a fill pop, with a second fill still queued.
      t0 = cyc;
      log_q.delete();
      send(OP_FILL, 3'd1, 24'h000010, '0);
      send(OP_FILL, 3'd2, 24'h000010, '0);
      idle(2);
      do_reset(1);
      idle(20);
      check("rstmid_no_rsp", 128'(log_q.size()), 128'd0);
      check("rstmid_valid", 128'(RspValid), 128'd0);
      t0 = cyc;
      send(OP_FILL, 3'd4, 24'h000010, '0);
      idle(14);
      check("rstmid_next_count", 128'(log_q.size()), 128'd1);
      if (log_q.size() > 0) begin
         check("rstmid_next_time", 128'(log_q[0].t - t0), 128'(RD_LAT + 1));
         check("rstmid_next_id", 128'(log_q[0].id), 128'd4);
         check("rstmid_next_data", log_q[0].data, D_E);
      end

      // Randomized traffic against the reference model.
      do_reset(2);
      mon_en = 1'b1;
      for (int i = 0; i < 800; i++) begin
         int r;
         logic [23:0] a;
         r = int'($urandom_range(0, 99));
         a = 24'($urandom);
         a[9:0] = 10'($urandom_range(0, 7));
         if (r < 8)       send(OP_FILL, 3'($urandom), a, '0);
         else if (r < 28) send(OP_EVICT, 3'($urandom), a,
                               {$urandom, $urandom, $urandom, $urandom});
         else if (r < 31) send(($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 3'd0, a, '0);
         else             step();
      end
      idle(150);
      mon_en = 1'b0;
      check("rnd_drained", 128'(exp_q.size()), 128'd0);
      check("rnd_ovf", 128'(FifoOverflow), 128'(m_ovf));
      check("rnd_badcnt", 128'(BadOpCnt), 128'(m_bad));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
